seq_divider: RTL and testbench

//   Multi-cycle restoring integer divider for the execute stage. Serves DIV/DIVU;
//   it is the subtract-and-restore counterpart to the ripple full-adder datapath.
//   One quotient bit is resolved per clock, with a start/busy/done handshake.
//   The pipeline stalls on busy and writes quotient/remainder to HI/LO on done.

---
 rtl/seq_divider.sv | 75 +++++++
 tb/tb_seq_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider (DIV/DIVU), one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r, dvd_raw;
    logic             neg_q, neg_r, zero_div;
    logic [WIDTH:0]   shifted, trial;
    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_r};
    assign busy    = (state == CALC) || (state == FIX);
    assign done    = state == DONE;
    // CALC spends one extra cycle at count==0 so done lands at E0+WIDTH+2
    always_comb begin
        state_nx = flush                           ? IDLE :
                   (state == IDLE && start)        ? CALC :
                   (state == CALC && count == '0)  ? FIX  :
                   (state == FIX)                  ? DONE :
                   (state == DONE)                 ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start && !flush) begin
                quo_r    <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                dvs_r    <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                rem_r    <= '0;
                dvd_raw  <= dividend;
                neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r    <= is_signed && dividend[WIDTH-1];
                zero_div <= divisor == '0;
                count    <= CW'(WIDTH);
            end
            if (state == CALC && count != '0) begin
                rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
                count <= count - 1'b1;
            end
            if (state == FIX && !flush) begin
                quotient    <= zero_div ? '1 : neg_q ? -quo_r : quo_r;
                remainder   <= zero_div ? dvd_raw : neg_r ? -rem_r : rem_r;
                div_by_zero <= zero_div;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and hand-sequenced checks of seq_divider with a result scoreboard
module tb_seq_divider;
    localparam int W = 32;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0, flush = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;
    vec_t vecs[12];
    vec_t sb[$];
    vec_t v100;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .flush(flush),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic launch(input vec_t v);
        @(negedge clk);
        dividend = v.a; divisor = v.b; is_signed = v.s; start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic finish_op(input int n);
        vec_t v;
        chk("latency", n, W + 2);
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            v = sb.pop_front();
            chk("quotient", quotient, v.q);
            chk("remainder", remainder, v.r);
            chk("div_by_zero", div_by_zero, v.z);
            chk("busy_in_done", busy, 0);
        end
    endtask
    initial begin
        int n;
        logic seen;
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[3]  = '{32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234,       1'b1};
        vecs[4]  = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
        vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        vecs[6]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
        vecs[8]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[9]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[10] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
        vecs[11] = '{32'hFFFFFFFF,   32'h10,         1'b0, 32'h0FFFFFFF,   32'hF,          1'b0};
        v100 = vecs[0];
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i]);
            wait_done(n);
            finish_op(n);
            @(posedge clk);
        end
        // second start mid-operation must be ignored
        launch(v100);
        repeat (4) @(posedge clk);
        #1 dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        finish_op(n + 5);
        // start held through the DONE cycle: ignored there, accepted on the next IDLE edge
        dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 chk("start_in_done_ignored", busy, 0);
        sb.push_back('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_after_done_accepted", busy, 1);
        wait_done(n);
        finish_op(n);
        @(posedge clk);
        // flush at E0+10
        launch(v100);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_keeps_quotient", quotient, 3);
        chk("flush_keeps_remainder", remainder, 0);
        chk("flush_keeps_dbz", div_by_zero, 0);
        seen = 1'b0;
        repeat (W + 6) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        chk("no_done_after_flush", seen, 0);
        chk("flush_quotient_later", quotient, 3);
        void'(sb.pop_back());
        // asynchronous reset at E0+10
        launch(v100);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_dbz", div_by_zero, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        launch(v100);
        wait_done(n);
        finish_op(n);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
